// File: rtl/comp_strg_alu.sv
// Computation-storage block: word memory with in-place ALU commands behind a ready/valid FSM.
// Optional build macro COMP_STRG_SAT_EN makes ADD/SUB saturate instead of wrap.
module comp_strg_alu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            cmd,
    input  logic [ADDR_WIDTH-1:0] addA,
    input  logic [ADDR_WIDTH-1:0] addB,
    input  logic [ADDR_WIDTH-1:0] addC,
    inout  wire  [DATA_WIDTH-1:0] DQ,
    output logic                  ready,
    output logic                  valid_out,
    output logic                  ovf
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_ADD   = 3'd2;
    localparam logic [2:0] CMD_SUB   = 3'd3;
    localparam logic [2:0] CMD_AND   = 3'd4;
    localparam logic [2:0] CMD_OR    = 3'd5;
    localparam logic [2:0] CMD_XOR   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WR,
        S_DONE
    } state_t;

    state_t                  state;
    logic [2:0]              cmd_q;
    logic [ADDR_WIDTH-1:0]   addr_a_q;
    logic [ADDR_WIDTH-1:0]   addr_b_q;
    logic [ADDR_WIDTH-1:0]   addr_c_q;
    logic [DATA_WIDTH-1:0]   dq_q;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic [DATA_WIDTH-1:0]   result;
    logic                    dq_oe;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH:0]     sum_c;
    logic [DATA_WIDTH:0]     diff_c;
    logic [DATA_WIDTH-1:0]   alu_c;
    logic                    carry_c;

    // ALU on the fetched operands; the extra MSB of sum/diff is carry/borrow
    always_comb begin
        sum_c   = {1'b0, op_a} + {1'b0, op_b};
        diff_c  = {1'b0, op_a} - {1'b0, op_b};
        alu_c   = op_a;
        carry_c = 1'b0;
        case (cmd_q)
            CMD_ADD: begin
                alu_c   = sum_c[DATA_WIDTH-1:0];
                carry_c = sum_c[DATA_WIDTH];
`ifdef COMP_STRG_SAT_EN
                if (carry_c) alu_c = '1;
`endif
            end
            CMD_SUB: begin
                alu_c   = diff_c[DATA_WIDTH-1:0];
                carry_c = diff_c[DATA_WIDTH];
`ifdef COMP_STRG_SAT_EN
                if (carry_c) alu_c = '0;
`endif
            end
            CMD_AND: alu_c = op_a & op_b;
            CMD_OR:  alu_c = op_a | op_b;
            CMD_XOR: alu_c = op_a ^ op_b;
            default: alu_c = op_a;
        endcase
    end

    // Storage is never reset; an async reset pulls state out of EXEC/WR so no commit happens
    always_ff @(posedge clk) begin
        if (state == S_EXEC && cmd_q != CMD_READ) mem[addr_c_q] <= alu_c;
        if (state == S_WR) mem[addr_a_q] <= dq_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            valid_out <= 1'b0;
            ovf       <= 1'b0;
            dq_oe     <= 1'b0;
            cmd_q     <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
            dq_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
        end else begin
            valid_out <= 1'b0;
            dq_oe     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        cmd_q    <= cmd;
                        addr_a_q <= addA;
                        addr_b_q <= addB;
                        addr_c_q <= addC;
                        ready    <= 1'b0;
                        ovf      <= 1'b0;
                        if (cmd == CMD_WRITE) begin
                            dq_q  <= DQ;
                            state <= S_WR;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    op_a  <= mem[addr_a_q];
                    op_b  <= mem[addr_b_q];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result    <= alu_c;
                    ovf       <= carry_c;
                    valid_out <= 1'b1;
                    dq_oe     <= (cmd_q == CMD_READ);
                    state     <= S_DONE;
                end
                S_WR: begin
                    ovf       <= 1'b0;
                    valid_out <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    ready <= 1'b1;
                    ovf   <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign DQ = dq_oe ? result : {DATA_WIDTH{1'bz}};

endmodule
